dmem_arbiter: RTL and testbench

- Shares the single-port 8-bit data memory between two requesters: port 0 is the core load/store stage, port 1 is the program/data loader (DMA).
- Drives the memory's write-enable, address and write-data, and registers read data back to the winning requester.
- Uses a burst-aware round-robin FSM, so a streaming requester keeps the memory without starving the other.

---
 rtl/dmem_arbiter.sv | 154 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between the core
// load/store stage (port 0) and the loader DMA (port 1) using a
// burst-aware round-robin FSM.
// Optional build macro DMEM_ARB_STATS_EN adds a 16-bit saturating
// conflict counter output (conflict_cnt).
module dmem_arbiter #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [1:0]        req_valid,
    input  logic [1:0]        req_write,
    input  logic [ADDR_W-1:0] req_addr0,
    input  logic [ADDR_W-1:0] req_addr1,
    input  logic [DATA_W-1:0] req_wdata0,
    input  logic [DATA_W-1:0] req_wdata1,
    output logic [1:0]        req_ready,
    output logic [1:0]        rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [15:0]       conflict_cnt
`endif
);

    typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

    localparam logic [3:0] MaxBurst = 4'(MAX_BURST);

    state_e            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic [3:0]        burst_cnt_q, burst_cnt_d;
    logic [1:0]        rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

    logic gnt_en;    // arbitration found a winner
    logic gnt_idx;   // winning port
    logic gnt_live;  // winner, suppressed while reset is high
    logic own;
    logic oth;

    // Arbitration and next-state for FSM, ownership and burst count
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        burst_cnt_d  = burst_cnt_q;
        gnt_en       = 1'b0;
        gnt_idx      = 1'b0;
        own          = (state_q == StOwn1);
        oth          = ~own;
        unique case (state_q)
            StIdle: begin
                if (|req_valid) begin
                    gnt_en  = 1'b1;
                    // On conflict the port that did not win last time goes first
                    gnt_idx = (&req_valid) ? ~last_grant_q : req_valid[1];
                end
            end
            default: begin
                if (req_valid[own] && (!req_valid[oth] || burst_cnt_q < MaxBurst)) begin
                    gnt_en  = 1'b1;
                    gnt_idx = own;
                end else if (req_valid[oth]) begin
                    gnt_en  = 1'b1;
                    gnt_idx = oth;
                end
            end
        endcase
        if (gnt_en) begin
            if (state_q != StIdle && gnt_idx == own) begin
                if (burst_cnt_q < MaxBurst) begin
                    burst_cnt_d = burst_cnt_q + 4'd1;
                end
            end else begin
                state_d      = gnt_idx ? StOwn1 : StOwn0;
                burst_cnt_d  = 4'd1;
                last_grant_d = gnt_idx;
            end
        end else begin
            state_d = StIdle;
        end
    end

    // Memory-side and handshake outputs driven from the current winner
    always_comb begin
        gnt_live    = gnt_en & ~reset;
        req_ready   = 2'b00;
        mem_write   = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        rsp_valid_d = 2'b00;
        rsp_rdata_d = rsp_rdata_q;
        if (gnt_live) begin
            req_ready = gnt_idx ? 2'b10 : 2'b01;
            mem_write = req_write[gnt_idx] & req_valid[gnt_idx];
            mem_addr  = gnt_idx ? req_addr1 : req_addr0;
            mem_wdata = gnt_idx ? req_wdata1 : req_wdata0;
            if (!req_write[gnt_idx]) begin
                rsp_valid_d = req_ready;
                rsp_rdata_d = mem_rdata;
            end
        end
    end

    // State, ownership and load-response registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            burst_cnt_q  <= 4'd0;
            rsp_valid_q  <= 2'b00;
            rsp_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            burst_cnt_q  <= burst_cnt_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] conflict_q, conflict_d;

    // Count cycles where both ports want the memory (one must lose)
    always_comb begin
        conflict_d = conflict_q;
        if ((&req_valid) && (conflict_q != 16'hFFFF)) begin
            conflict_d = conflict_q + 16'd1;
        end
    end

    // Conflict counter register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            conflict_q <= 16'd0;
        end else begin
            conflict_q <= conflict_d;
        end
    end

    assign conflict_cnt = conflict_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a
// behavioural model (arbitration rules, reference memory, response queue).
module tb_dmem_arbiter;

    localparam int MAXB = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] req_valid = 2'b00;
    logic [1:0] req_write = 2'b00;
    logic [7:0] req_addr0 = 8'h00, req_addr1 = 8'h00;
    logic [7:0] req_wdata0 = 8'h00, req_wdata1 = 8'h00;
    logic [1:0] req_ready, rsp_valid;
    logic [7:0] rsp_rdata, mem_addr, mem_wdata, mem_rdata;
    logic       mem_write;
`ifdef DMEM_ARB_STATS_EN
    logic [15:0] conflict_cnt;
`endif

    dmem_arbiter #(.ADDR_W(8), .DATA_W(8), .MAX_BURST(MAXB)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_addr0  (req_addr0),
        .req_addr1  (req_addr1),
        .req_wdata0 (req_wdata0),
        .req_wdata1 (req_wdata1),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
`ifdef DMEM_ARB_STATS_EN
        ,
        .conflict_cnt (conflict_cnt)
`endif
    );

    always #5 clock = ~clock;

    // Environment memory: combinational read, write at the clock edge
    logic [7:0] env_mem [256];
    assign mem_rdata = env_mem[mem_addr];
    always @(posedge clock) if (mem_write) env_mem[mem_addr] <= mem_wdata;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] ref_mem [256];
    int         m_owner = -1;  // port holding the memory, -1 when idle
    int         m_streak = 0;  // consecutive grants to the owner (capped)
    int         m_last = 1;
    logic [1:0] m_rsp_v = 2'b00;
    logic [7:0] m_rsp_d = 8'h00;
    int         m_conf = 0;
    int         n_owner = -1, n_streak = 0, n_last = 1, n_conf = 0;
    logic [1:0] n_rsp_v = 2'b00;
    logic [7:0] n_rsp_d = 8'h00;
    logic       n_wr_en = 1'b0;
    logic [7:0] n_wr_addr = 8'h00, n_wr_data = 8'h00;
    int         wait_c [2] = '{0, 0};

    // Compare process: evaluates the model mid-cycle and checks every output
    always @(negedge clock) begin : compare
        int g;
        int o;
        logic [1:0] v;
        logic [1:0] e_ready;
        logic [7:0] e_addr, e_wdata;
        logic e_write;
        if (reset) begin
            check("rst_ready", req_ready, 2'b00);
            check("rst_mem_write", mem_write, 1'b0);
            check("rst_mem_addr", mem_addr, 8'h00);
            check("rst_rsp_valid", rsp_valid, 2'b00);
            n_owner = -1; n_streak = 0; n_last = 1; n_rsp_v = 2'b00; n_rsp_d = 8'h00;
            n_wr_en = 1'b0; n_conf = 0;
            wait_c[0] = 0; wait_c[1] = 0;
        end else begin
            v = req_valid;
            g = -1;
            if (m_owner < 0) begin
                if (v == 2'b11) g = 1 - m_last;
                else if (v[0]) g = 0;
                else if (v[1]) g = 1;
            end else begin
                o = 1 - m_owner;
                if (v[m_owner] && (!v[o] || m_streak < MAXB)) g = m_owner;
                else if (v[o]) g = o;
            end
            e_ready = 2'b00; e_write = 1'b0; e_addr = 8'h00; e_wdata = 8'h00;
            if (g >= 0) begin
                e_ready = (g == 1) ? 2'b10 : 2'b01;
                e_write = req_write[g];
                e_addr  = (g == 1) ? req_addr1 : req_addr0;
                e_wdata = (g == 1) ? req_wdata1 : req_wdata0;
            end
            check("req_ready", req_ready, e_ready);
            check("mem_write", mem_write, e_write);
            check("mem_addr", mem_addr, e_addr);
            check("mem_wdata", mem_wdata, e_wdata);
            check("rsp_valid", rsp_valid, m_rsp_v);
            check("rsp_rdata", rsp_rdata, m_rsp_d);
`ifdef DMEM_ARB_STATS_EN
            check("conflict_cnt", conflict_cnt, m_conf);
            n_conf = (v == 2'b11 && m_conf < 65535) ? m_conf + 1 : m_conf;
`endif
            n_rsp_v = 2'b00; n_rsp_d = m_rsp_d; n_wr_en = 1'b0;
            n_owner = m_owner; n_streak = m_streak; n_last = m_last;
            if (g >= 0) begin
                if (g == m_owner) begin
                    n_streak = (m_streak < MAXB) ? m_streak + 1 : MAXB;
                end else begin
                    n_owner = g; n_streak = 1; n_last = g;
                end
                if (e_write) begin
                    n_wr_en = 1'b1; n_wr_addr = e_addr; n_wr_data = e_wdata;
                end else begin
                    n_rsp_v = e_ready; n_rsp_d = ref_mem[e_addr];
                end
            end else begin
                n_owner = -1;
            end
            // No valid requester may be kept waiting beyond the burst cap
            for (int i = 0; i < 2; i++) begin
                if (v[i] && g == i) begin
                    check("wait_bound", (wait_c[i] <= MAXB), 1'b1);
                    wait_c[i] = 0;
                end else if (v[i]) begin
                    wait_c[i]++;
                end else begin
                    wait_c[i] = 0;
                end
            end
        end
    end

    // Model state advance at the clock edge; reset clears it asynchronously
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_owner <= -1; m_streak <= 0; m_last <= 1;
            m_rsp_v <= 2'b00; m_rsp_d <= 8'h00; m_conf <= 0;
        end else begin
            m_owner <= n_owner; m_streak <= n_streak; m_last <= n_last;
            m_rsp_v <= n_rsp_v; m_rsp_d <= n_rsp_d; m_conf <= n_conf;
            if (n_wr_en) ref_mem[n_wr_addr] <= n_wr_data;
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic [1:0] v, input logic [1:0] w, input logic [7:0] a0,
                         input logic [7:0] a1, input logic [7:0] d0, input logic [7:0] d1);
        @(posedge clock);
        #1;
        req_valid = v; req_write = w;
        req_addr0 = a0; req_addr1 = a1; req_wdata0 = d0; req_wdata1 = d1;
    endtask

    task automatic do_reset();
        @(posedge clock);
        #1;
        reset = 1'b1;
        req_valid = 2'b00;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    int exp_seq [10] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};

    initial begin
        for (int i = 0; i < 256; i++) begin
            env_mem[i] = 8'(i * 3 + 7);
            ref_mem[i] = 8'(i * 3 + 7);
        end

        // Store then load same address
        do_reset();
        drive(2'b01, 2'b01, 8'h10, 8'h00, 8'h5A, 8'h00);
        @(negedge clock);
        check("st_ready", req_ready, 2'b01);
        check("st_write", mem_write, 1'b1);
        drive(2'b01, 2'b00, 8'h10, 8'h00, 8'h00, 8'h00);
        @(negedge clock);
        check("ld_ready", req_ready, 2'b01);
        check("ld_no_rsp_yet", rsp_valid, 2'b00);
        drive(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
        @(negedge clock);
        check("ld_rsp_valid", rsp_valid, 2'b01);
        check("ld_rsp_data", rsp_rdata, 8'h5A);

        // First conflict after reset: port 0 wins, port 1 next
        do_reset();
        drive(2'b11, 2'b00, 8'h01, 8'h02, 8'h00, 8'h00);
        @(negedge clock);
        check("conf_first", req_ready, 2'b01);
        drive(2'b10, 2'b00, 8'h01, 8'h02, 8'h00, 8'h00);
        @(negedge clock);
        check("conf_second", req_ready, 2'b10);
        check("conf_rsp0_v", rsp_valid, 2'b01);
        check("conf_rsp0_d", rsp_rdata, 8'h0A);
        drive(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
        @(negedge clock);
        check("conf_rsp1_v", rsp_valid, 2'b10);
        check("conf_rsp1_d", rsp_rdata, 8'h0D);

        // Both streaming: bursts of MAX_BURST alternate
        do_reset();
        for (int k = 0; k < 10; k++) begin
            drive(2'b11, 2'b00, 8'(k), 8'(k + 32), 8'h00, 8'h00);
            @(negedge clock);
            check("burst_seq", req_ready, (exp_seq[k] == 1) ? 2'b10 : 2'b01);
        end

        // Port 1 alone, 10 back-to-back loads, then a saturated cap yields at once
        do_reset();
        for (int k = 0; k < 10; k++) begin
            drive(2'b10, 2'b00, 8'h00, 8'(k + 64), 8'h00, 8'h00);
            @(negedge clock);
            check("solo_ready", req_ready, 2'b10);
        end
        drive(2'b11, 2'b00, 8'h03, 8'h4A, 8'h00, 8'h00);
        @(negedge clock);
        check("solo_sat_yield", req_ready, 2'b01);

        // Reset during a port 1 load accept cycle drops the response
        do_reset();
        drive(2'b10, 2'b00, 8'h00, 8'h05, 8'h00, 8'h00);
        @(negedge clock);
        check("rst_acc_ready", req_ready, 2'b10);
        #2;
        reset = 1'b1;
        req_valid = 2'b00;
        @(posedge clock);
        #1;
        check("rst_acc_drop", rsp_valid, 2'b00);
        @(posedge clock);
        #1;
        reset = 1'b0;
        drive(2'b11, 2'b00, 8'h06, 8'h07, 8'h00, 8'h00);
        @(negedge clock);
        check("rst_acc_p0_wins", req_ready, 2'b01);
        check("rst_acc_no_rsp", rsp_valid, 2'b00);

`ifdef DMEM_ARB_STATS_EN
        do_reset();
        repeat (6) drive(2'b11, 2'b00, 8'h01, 8'h02, 8'h00, 8'h00);
        drive(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
        @(negedge clock);
        check("stats_six", conflict_cnt, 16'd6);
`endif

        // Randomized traffic over a small address window to provoke hazards
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            drive({($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)},
                  2'($urandom_range(0, 3)), 8'($urandom_range(0, 15)),
                  8'($urandom_range(0, 15)), 8'($urandom), 8'($urandom));
        end
        drive(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
        repeat (3) @(posedge clock);
        @(negedge clock);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
